// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures an incoming PWM waveform and recovers its duty
// step in 1/T_DIV units, plus the measured period and high time. It also flags
// a stuck line (no rising edge for T_TIMEOUT cycles) and off-nominal periods.
//
// Optional build macro: PWM_CAP_GLITCH_FILTER_EN
//   Defined: the synchronized input must hold a new level for FILT_LEN cycles
//   before it is accepted. All latencies grow by FILT_LEN.
//   Undefined: every pulse of at least one cycle counts.
//
// Ports:
//   SYSCLK   in   1      system clock
//   RST      in   1      synchronous, active-high reset
//   PWM_IN   in   1      asynchronous PWM input
//   DUTY     out  7      rounded duty step 0..T_DIV
//   PERIOD   out  CNT_W  last measured period (cycles)
//   HIGH_T   out  CNT_W  last measured high time (cycles)
//   VALID    out  1      one-cycle pulse: result outputs just updated
//   STUCK    out  1      level: no rising edge for T_TIMEOUT cycles
//   PER_ERR  out  1      level: last period off-nominal or too short
module pwm_duty_capture #(
  parameter int unsigned T_INM     = 1000000,
  parameter int unsigned T_DIV     = 20,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned T_TIMEOUT = 2 * T_INM,
  parameter int unsigned TOL       = T_INM / 8,
  parameter int unsigned MIN_PER   = 16
`ifdef PWM_CAP_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILT_LEN  = 4
`endif
) (
  input  logic             SYSCLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [6:0]       DUTY,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_T,
  output logic             VALID,
  output logic             STUCK,
  output logic             PER_ERR
);

  localparam int unsigned NW = CNT_W + 5;   // dividend width
  localparam int unsigned DW = CNT_W + 6;   // divisor pre-shifted by 6

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(T_TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_PER_V = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] PER_LO_V  = CNT_W'(T_INM - TOL);
  localparam logic [CNT_W-1:0] PER_HI_V  = CNT_W'(T_INM + TOL);
  localparam logic [6:0]       T_DIV_V   = 7'(T_DIV);

  typedef enum logic [1:0] {
    ST_ARM,
    ST_MEAS,
    ST_DIV,
    ST_STUCK
  } state_t;

  state_t state, state_nxt;

  logic sync_meta, sync_out, s, s_prev;
  logic edge_c;

  logic [CNT_W-1:0] per_cnt, high_cnt;
  logic [CNT_W-1:0] snap_p, snap_h;

  logic [NW-1:0] div_rem;
  logic [DW-1:0] div_dsh;
  logic [5:0]    div_q;
  logic [2:0]    div_step;

  logic [DW-1:0] rem_ext_c;
  logic          ge_c;
  logic [NW-1:0] rem_sub_c;
  logic [NW-1:0] n_c;
  logic [6:0]    q_fin_c;
  logic          timeout_c;
  logic          start_div_c;

  logic [6:0]       duty_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             valid_nxt, stuck_nxt, per_err_nxt;

  // Two-flop synchronizer for the asynchronous pad input
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= PWM_IN;
      sync_out  <= sync_meta;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] filt_cnt;
  logic          s_filt;

  // Accept a new level only after it has been stable for FILT_LEN cycles
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      s_filt   <= 1'b0;
      filt_cnt <= '0;
    end else if (sync_out == s_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      s_filt   <= sync_out;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign s = s_filt;
`else
  assign s = sync_out;
`endif

  // Rising-edge detector on the cleaned line
  always_ff @(posedge SYSCLK) begin
    if (RST) s_prev <= 1'b0;
    else     s_prev <= s;
  end

  assign edge_c = s & ~s_prev;

  // Period and high-time counters; both restart on every rising edge
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else if (edge_c) begin
      per_cnt  <= CNT_W'(1);
      high_cnt <= CNT_W'(1);
    end else begin
      if (per_cnt < TIMEOUT_V) per_cnt <= per_cnt + CNT_W'(1);
      if (s && (high_cnt < TIMEOUT_V)) high_cnt <= high_cnt + CNT_W'(1);
    end
  end

  assign timeout_c   = (per_cnt >= TIMEOUT_V);
  assign start_div_c = (state == ST_MEAS) && edge_c && (per_cnt >= MIN_PER_V);

  // Rounded dividend: H*T_DIV + P/2 so that floor(N/P) rounds to nearest
  assign n_c = NW'(high_cnt) * NW'(T_DIV) + NW'(per_cnt >> 1);

  // One restoring-division step per cycle, MSB of the 7-bit quotient first
  assign rem_ext_c = DW'(div_rem);
  assign ge_c      = (rem_ext_c >= div_dsh);
  assign rem_sub_c = NW'(rem_ext_c - div_dsh);
  assign q_fin_c   = {div_q, ge_c};

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      div_rem  <= '0;
      div_dsh  <= '0;
      div_q    <= '0;
      div_step <= '0;
      snap_p   <= '0;
      snap_h   <= '0;
    end else if (start_div_c) begin
      div_rem  <= n_c;
      div_dsh  <= {per_cnt, 6'b0};
      div_q    <= '0;
      div_step <= '0;
      snap_p   <= per_cnt;
      snap_h   <= high_cnt;
    end else if (state == ST_DIV) begin
      if (ge_c) div_rem <= rem_sub_c;
      div_q    <= {div_q[4:0], ge_c};
      div_dsh  <= div_dsh >> 1;
      div_step <= div_step + 3'd1;
    end
  end

  // FSM state register
  always_ff @(posedge SYSCLK) begin
    if (RST) state <= ST_ARM;
    else     state <= state_nxt;
  end

  // Next state and next values of the registered result outputs
  always_comb begin
    state_nxt   = state;
    duty_nxt    = DUTY;
    period_nxt  = PERIOD;
    high_nxt    = HIGH_T;
    stuck_nxt   = STUCK;
    per_err_nxt = PER_ERR;
    valid_nxt   = 1'b0;

    case (state)
      ST_ARM, ST_MEAS: begin
        if (edge_c) begin
          if (state == ST_ARM) begin
            state_nxt = ST_MEAS;
          end else if (per_cnt < MIN_PER_V) begin
            // Too short to divide: flag it, keep the previous result
            per_err_nxt = 1'b1;
            valid_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DIV;
          end
        end else if (timeout_c) begin
          state_nxt   = ST_STUCK;
          stuck_nxt   = 1'b1;
          duty_nxt    = s ? T_DIV_V : 7'd0;
          period_nxt  = '0;
          high_nxt    = '0;
          per_err_nxt = 1'b1;
          valid_nxt   = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_step == 3'd6) begin
          state_nxt   = ST_MEAS;
          duty_nxt    = q_fin_c;
          period_nxt  = snap_p;
          high_nxt    = snap_h;
          per_err_nxt = (snap_p < PER_LO_V) || (snap_p > PER_HI_V);
          stuck_nxt   = 1'b0;
          valid_nxt   = 1'b1;
        end
      end
      ST_STUCK: begin
        if (edge_c) begin
          state_nxt = ST_MEAS;
          stuck_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  // Registered result outputs
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      DUTY    <= '0;
      PERIOD  <= '0;
      HIGH_T  <= '0;
      VALID   <= 1'b0;
      STUCK   <= 1'b0;
      PER_ERR <= 1'b0;
    end else begin
      DUTY    <= duty_nxt;
      PERIOD  <= period_nxt;
      HIGH_T  <= high_nxt;
      VALID   <= valid_nxt;
      STUCK   <= stuck_nxt;
      PER_ERR <= per_err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture: directed and random PWM periods,
// compared against a period-level reference model (one expected result per
// rising edge, computed with plain arithmetic).
module tb_pwm_duty_capture;

  localparam int unsigned CNT_W     = 21;
  localparam int unsigned T_INM     = 100;
  localparam int unsigned T_DIV     = 20;
  localparam int unsigned T_TIMEOUT = 200;
  localparam int unsigned TOL       = 12;
  localparam int unsigned MIN_PER   = 16;

  // Fixed latencies from the input rise (driven just after posedge k)
  localparam int LAT_DIV   = 10;
  localparam int LAT_SHORT = 3;
  localparam int LAT_TO    = 203;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [6:0]       duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_t;
  logic             valid;
  logic             stuck;
  logic             per_err;

  pwm_duty_capture #(
    .T_INM     (T_INM),
    .T_DIV     (T_DIV),
    .CNT_W     (CNT_W),
    .T_TIMEOUT (T_TIMEOUT),
    .TOL       (TOL),
    .MIN_PER   (MIN_PER)
  ) dut (
    .SYSCLK  (clk),
    .RST     (rst),
    .PWM_IN  (pwm_in),
    .DUTY    (duty),
    .PERIOD  (period),
    .HIGH_T  (high_t),
    .VALID   (valid),
    .STUCK   (stuck),
    .PER_ERR (per_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint cyc;
    int     duty;
    int     period;
    int     high;
    int     stuck;
    int     per_err;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit     prev_ok;
  longint prev_k;
  int     prev_h;
  int     last_duty, last_period, last_high;
  bit     stuck_pending;
  longint stuck_clr_cyc = -10;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_duty(input int h, input int p);
    return (h * int'(T_DIV) + p / 2) / p;
  endfunction

  // Called at each rising edge k with this period's high/low lengths
  task automatic model_rise(input longint k, input int h, input int l);
    exp_t e;
    if (prev_ok) begin
      int p;
      p = int'(k - prev_k);
      if (p < int'(MIN_PER)) begin
        e = '{k + LAT_SHORT, last_duty, last_period, last_high, 0, 1};
      end else begin
        last_duty   = ref_duty(prev_h, p);
        last_period = p;
        last_high   = prev_h;
        e = '{k + LAT_DIV, last_duty, p, prev_h, 0,
              ((p < int'(T_INM - TOL)) || (p > int'(T_INM + TOL))) ? 1 : 0};
      end
      exp_q.push_back(e);
    end
    if (stuck_pending) begin
      stuck_clr_cyc = k + 3;
      stuck_pending = 1'b0;
    end
    if (h + l > int'(T_TIMEOUT)) begin
      // Line sampled 200 cycles after the edge decides the stuck level
      last_duty   = (h > int'(T_TIMEOUT)) ? int'(T_DIV) : 0;
      last_period = 0;
      last_high   = 0;
      e = '{k + LAT_TO, last_duty, 0, 0, 1, 1};
      exp_q.push_back(e);
      prev_ok       = 1'b0;
      stuck_pending = 1'b1;
    end else begin
      prev_ok = 1'b1;
    end
    prev_k = k;
    prev_h = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int h, input int l);
    tick();
    pwm_in = 1'b1;
    model_rise(cyc, h, l);
    repeat (h - 1) tick();
    tick();
    pwm_in = 1'b0;
    repeat (l - 1) tick();
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    pwm_in = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    stuck_clr_cyc = -10;
    repeat (n) tick();
    rst           = 1'b0;
    prev_ok       = 1'b0;
    stuck_pending = 1'b0;
    last_duty     = 0;
    last_period   = 0;
    last_high     = 0;
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_period", period, 0);
    check("rst_high", high_t, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_per_err", per_err, 0);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("valid_missed", 0, 1);
      void'(exp_q.pop_front());
    end
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("valid_unexp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("valid_cyc", cyc, e.cyc);
        check("duty", duty, e.duty);
        check("period", period, e.period);
        check("high_t", high_t, e.high);
        check("stuck", stuck, e.stuck);
        check("per_err", per_err, e.per_err);
      end
    end
    if (cyc == stuck_clr_cyc - 1) check("stuck_hold", stuck, 1);
    if (cyc == stuck_clr_cyc)     check("stuck_clr", stuck, 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, h, r;
    int bnd[6];
    bnd = '{87, 88, 112, 113, 200, 16};
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) tick();
    do_reset(4);

    // Nominal 25 % and rounding cases
    drive_period(25, 75);
    drive_period(25, 75);
    drive_period(25, 75);
    drive_period(37, 63);
    drive_period(38, 62);
    // Long period, then too-short period, then recovery
    drive_period(65, 65);
    drive_period(5, 5);
    drive_period(25, 75);
    // Tolerance boundaries and timeout/edge coincidence
    drive_period(20, 68);
    drive_period(50, 62);
    drive_period(30, 57);
    drive_period(40, 73);
    drive_period(100, 100);
    // Low glitch inside the high phase
    drive_period(10, 2);
    drive_period(13, 75);
    // Stuck high, then stuck low, then normal again
    drive_period(250, 30);
    drive_period(30, 230);
    drive_period(25, 75);
    drive_period(25, 75);

    // Reset in the middle of a divide
    tick();
    pwm_in = 1'b1;
    model_rise(cyc, 25, 75);
    repeat (6) tick();
    do_reset(3);
    drive_period(40, 60);
    drive_period(40, 60);
    drive_period(40, 60);

    // Random periods, including short, boundary and timeout cases
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      p = int'($urandom_range(8, 15));
      else if (r == 1) p = int'($urandom_range(201, 240));
      else if (r == 2) p = bnd[$urandom_range(0, 5)];
      else             p = int'($urandom_range(16, 200));
      h = int'($urandom_range(1, p - 1));
      drive_period(h, p - h);
    end

    drive_period(25, 75);
    repeat (20) tick();
    check("pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
